// File: rtl/bus_dma_pkg.sv
// Shared definitions for bus_dma: FSM state encoding, register word
// indices and CTRL/STATUS bit positions.
package bus_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam logic [2:0] REG_SRC     = 3'd0;
  localparam logic [2:0] REG_DST     = 3'd1;
  localparam logic [2:0] REG_COUNT   = 3'd2;
  localparam logic [2:0] REG_CTRL    = 3'd3;
  localparam logic [2:0] REG_PATTERN = 3'd4;

  localparam int CTRL_START   = 0;
  localparam int CTRL_BUSY    = 1;
  localparam int CTRL_DONE    = 2;
  localparam int CTRL_IRQ_EN  = 3;
  localparam int CTRL_FILL    = 4;
  localparam int CTRL_ABORT   = 5;
  localparam int CTRL_ABORTED = 6;

endpackage

// File: rtl/bus_dma.sv
// bus_dma: single-channel word-copy DMA with a register responder port and
// a bus initiator port. Each beat is one read (SRC) followed by one write
// (DST). Optional fill mode is compiled in with macro BUS_DMA_FILL_EN: every
// beat is then a write of PATTERN and SRC does not advance.
//
// Bus handshake: a request (m_read or m_write) with its address/data is
// presented from registered state and held unchanged until a cycle in which
// m_waitrequest is low; that rising edge completes the transfer.
module bus_dma
  import bus_dma_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic        irq
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [31:0]      src_q, dst_q, buf_q, rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q, done_d, irq_en_q, irq_en_d;
  logic             aborted_q, aborted_d, abort_q, abort_d, irq_q;
  logic             busy, ctrl_wr, reg_wr, start_go, rd_ack, wr_ack;
  logic             fill_on, fill_go;
  logic [31:0]      pat_val;

  assign busy     = (state_q == ST_RD) || (state_q == ST_WR);
  assign ctrl_wr  = s_write && (s_address == REG_CTRL);
  assign reg_wr   = s_write && !busy;
  assign start_go = ctrl_wr && s_writedata[CTRL_START] && (state_q == ST_IDLE);
  assign rd_ack   = (state_q == ST_RD) && !m_waitrequest;
  assign wr_ack   = (state_q == ST_WR) && !m_waitrequest;

`ifdef BUS_DMA_FILL_EN
  logic        fill_q;
  logic [31:0] pat_q;

  assign fill_on = fill_q;
  assign pat_val = pat_q;
  assign fill_go = s_writedata[CTRL_FILL];

  // Fill-mode registers; FILL is frozen during a transfer so the beat type cannot change mid-run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= 1'b0;
      pat_q  <= '0;
    end else begin
      if (reg_wr && (s_address == REG_PATTERN)) pat_q <= s_writedata;
      if (ctrl_wr && !busy) fill_q <= s_writedata[CTRL_FILL];
    end
  end
`else
  assign fill_on = 1'b0;
  assign pat_val = '0;
  assign fill_go = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state; a pending abort is honoured only once a write beat completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_go) begin
        if (cnt_q == '0)  state_d = ST_FIN;
        else if (fill_go) state_d = ST_WR;
        else              state_d = ST_RD;
      end
      ST_RD:   if (!m_waitrequest) state_d = ST_WR;
      ST_WR:   if (!m_waitrequest) begin
        if (abort_q || (cnt_q == CNT_ONE)) state_d = ST_FIN;
        else if (fill_on)                  state_d = ST_WR;
        else                               state_d = ST_RD;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Initiator outputs decoded from registered state, so they hold during stalls.
  always_comb begin
    m_read      = 1'b0;
    m_write     = 1'b0;
    m_address   = '0;
    m_writedata = '0;
    case (state_q)
      ST_RD: begin
        m_read    = 1'b1;
        m_address = src_q;
      end
      ST_WR: begin
        m_write     = 1'b1;
        m_address   = dst_q;
        m_writedata = fill_on ? pat_val : buf_q;
      end
      default: ;
    endcase
  end

  assign m_byteenable = 4'hF;

  // Address/count registers: host writes when not busy, live progress on write beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      if (reg_wr) begin
        case (s_address)
          REG_SRC:   src_q <= {s_writedata[31:2], 2'b00};
          REG_DST:   dst_q <= {s_writedata[31:2], 2'b00};
          REG_COUNT: cnt_q <= s_writedata[CNT_W-1:0];
          default: ;
        endcase
      end
      if (rd_ack) buf_q <= m_readdata;
      if (wr_ack) begin
        if (!fill_on) src_q <= src_q + 32'd4;
        dst_q <= dst_q + 32'd4;
        cnt_q <= cnt_q - CNT_ONE;
      end
    end
  end

  // Control/status next values; FIN setting DONE wins over a same-cycle clear.
  always_comb begin
    done_d    = done_q;
    irq_en_d  = irq_en_q;
    aborted_d = aborted_q;
    abort_d   = abort_q;
    if (ctrl_wr) begin
      irq_en_d = s_writedata[CTRL_IRQ_EN];
      if (s_writedata[CTRL_DONE])          done_d    = 1'b0;
      if (s_writedata[CTRL_ABORTED])       aborted_d = 1'b0;
      if (s_writedata[CTRL_ABORT] && busy) abort_d   = 1'b1;
    end
    if (state_q == ST_FIN) begin
      done_d = 1'b1;
      if (abort_q) aborted_d = 1'b1;
      abort_d = 1'b0;
    end
  end

  // Control/status flops; irq is registered from the next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      aborted_q <= 1'b0;
      abort_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      done_q    <= done_d;
      irq_en_q  <= irq_en_d;
      aborted_q <= aborted_d;
      abort_q   <= abort_d;
      irq_q     <= done_d & irq_en_d;
    end
  end

  // Register read mux; the result is captured only on a read strobe.
  always_comb begin
    rdata_d = rdata_q;
    if (s_read) begin
      rdata_d = '0;
      case (s_address)
        REG_SRC:   rdata_d = src_q;
        REG_DST:   rdata_d = dst_q;
        REG_COUNT: rdata_d = 32'(cnt_q);
        REG_CTRL: begin
          rdata_d[CTRL_BUSY]    = busy;
          rdata_d[CTRL_DONE]    = done_q;
          rdata_d[CTRL_IRQ_EN]  = irq_en_q;
          rdata_d[CTRL_FILL]    = fill_on;
          rdata_d[CTRL_ABORTED] = aborted_q;
        end
`ifdef BUS_DMA_FILL_EN
        REG_PATTERN: rdata_d = pat_q;
`endif
        default: rdata_d = '0;
      endcase
    end
  end

  // Registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign s_readdata = rdata_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_bus_dma.sv
// Testbench for bus_dma: register table vectors, directed multi-cycle
// sequences and randomized transfers checked against a memory-level model.
module tb_bus_dma;

  localparam int          CNT_W    = 16;
  localparam logic [31:0] CNT_MASK = (32'd1 << CNT_W) - 32'd1;
  localparam logic [2:0]  A_SRC = 3'd0, A_DST = 3'd1, A_CNT = 3'd2, A_CTRL = 3'd3, A_PAT = 3'd4;
`ifdef BUS_DMA_FILL_EN
  localparam bit HAS_FILL = 1'b1;
`else
  localparam bit HAS_FILL = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0, rst_n = 1'b1;
  logic [2:0]  s_address = '0;
  logic        s_read = 1'b0, s_write = 1'b0;
  logic [31:0] s_writedata = '0, s_readdata;
  logic [31:0] m_address, m_writedata, m_readdata = '0;
  logic        m_read, m_write, m_waitrequest = 1'b0, irq;
  logic [3:0]  m_byteenable;

  always #5 clk = ~clk;

  bus_dma #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest), .irq(irq)
  );

  // ---------------- scoreboard state ----------------
  int n_total = 0, n_pass = 0;
  logic [64:0] exp_q[$];               // {is_write, address, data}
  logic [64:0] act_q[$];
  logic [31:0] mem[logic [31:0]];      // memory seen by the bus responder
  logic [31:0] ref_mem[logic [31:0]];  // model's own view of memory

  // Bus responder knobs (written by the test) and statistics (written by the responder).
  int fixed_stall = 0, abort_at = 0;
  bit rand_stall = 1'b0;
  int n_rd_started = 0, stab_err = 0, proto_err = 0;
  bit in_beat = 1'b0;
  int stall_cnt = 0, beat_stall = 0;
  logic [31:0] beat_addr = '0, beat_wd = '0;
  logic        beat_rd = 1'b0;

  function automatic logic [31:0] bg(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Bus responder: chooses stall length per beat, checks hold-stable, logs accepted beats.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_waitrequest = 1'b0;
      in_beat = 1'b0;
      stall_cnt = 0;
    end else if (m_read || m_write) begin
      if (m_read && m_write) proto_err++;
      if (!in_beat) begin
        in_beat = 1'b1;
        beat_addr = m_address;
        beat_wd = m_writedata;
        beat_rd = m_read;
        stall_cnt = 0;
        if (m_read) n_rd_started++;
        if (m_read && abort_at != 0 && n_rd_started == abort_at) beat_stall = 20;
        else if (rand_stall) beat_stall = int'($urandom_range(0, 3));
        else beat_stall = fixed_stall;
      end else if (m_address !== beat_addr || m_read !== beat_rd ||
                   (m_write && m_writedata !== beat_wd)) begin
        stab_err++;
      end
      if (stall_cnt < beat_stall) begin
        m_waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        m_waitrequest = 1'b0;
        in_beat = 1'b0;
        if (beat_rd) begin
          m_readdata = mem.exists(beat_addr) ? mem[beat_addr] : bg(beat_addr);
          act_q.push_back({1'b0, beat_addr, m_readdata});
        end else begin
          mem[beat_addr] = beat_wd;
          act_q.push_back({1'b1, beat_addr, beat_wd});
        end
      end
    end else begin
      m_waitrequest = 1'b0;
      in_beat = 1'b0;
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_beat(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    s_address = a; s_writedata = d; s_write = 1'b1;
    @(negedge clk);
    s_write = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    s_address = a; s_read = 1'b1;
    @(negedge clk);
    s_read = 1'b0;
    d = s_readdata;
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return bg(a);
  endfunction

  int act_base, rd_base, stab_base, proto_base;

  // Program a transfer, build the expected bus log for 'beats' beats, then START.
  task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] cnt,
                            input int beats, input bit fill, input logic [31:0] pat,
                            input logic [31:0] ctrl);
    logic [31:0] a, d;
    reg_write(A_CTRL, 32'h44);
    reg_write(A_SRC, src);
    reg_write(A_DST, dst);
    reg_write(A_CNT, cnt);
    if (fill) reg_write(A_PAT, pat);
    exp_q.delete();
    act_base = act_q.size(); rd_base = n_rd_started;
    stab_base = stab_err; proto_base = proto_err;
    for (int i = 0; i < beats; i++) begin
      a = dst + 32'(4 * i);
      if (fill) d = pat;
      else begin
        d = ref_rd(src + 32'(4 * i));
        exp_q.push_back({1'b0, src + 32'(4 * i), d});
      end
      ref_mem[a] = d;
      exp_q.push_back({1'b1, a, d});
    end
    reg_write(A_CTRL, ctrl | 32'h1);
  endtask

  // Wait (bounded) for completion, then compare bus log and final registers.
  task automatic finish_xfer(input string tag, input logic [31:0] src, input logic [31:0] dst,
                             input logic [31:0] cnt, input int beats, input bit fill,
                             input logic [31:0] exp_status);
    logic [31:0] st, v;
    bit ok = 1'b0;
    st = '0;
    for (int k = 0; k < 400 && !ok; k++) begin
      reg_read(A_CTRL, st);
      ok = (st[1] == 1'b0) && (st[2] == 1'b1);
    end
    check({tag, "_status"}, st, exp_status);
    check({tag, "_nbeats"}, act_q.size() - act_base, exp_q.size());
    for (int i = 0; i < exp_q.size() && act_base + i < act_q.size(); i++)
      check_beat($sformatf("%s_beat%0d", tag, i), act_q[act_base + i], exp_q[i]);
    reg_read(A_SRC, v); check({tag, "_src"}, v, fill ? src : src + 32'(4 * beats));
    reg_read(A_DST, v); check({tag, "_dst"}, v, dst + 32'(4 * beats));
    reg_read(A_CNT, v); check({tag, "_count"}, v, (cnt - 32'(beats)) & CNT_MASK);
    check({tag, "_stable"}, 32'(stab_err - stab_base), 32'd0);
    check({tag, "_rdwr_excl"}, 32'(proto_err - proto_base), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  reg_vec_t vecs[11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, s, d, c;
    bit ien;
    int k;

    // ---- reset ----
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_m_read", 32'(m_read), 32'd0);
    check("rst_m_write", 32'(m_write), 32'd0);
    check("rst_m_address", m_address, 32'd0);
    check("rst_m_writedata", m_writedata, 32'd0);
    check("rst_byteenable", 32'(m_byteenable), 32'hF);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_readdata", s_readdata, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      reg_read(3'(i), v);
      check($sformatf("rst_reg%0d", i), v, 32'd0);
    end

    // ---- register table ----
    vecs[0]  = '{A_SRC,  32'h0000_0005, 32'h0000_0004};
    vecs[1]  = '{A_SRC,  32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[2]  = '{A_DST,  32'h1234_5677, 32'h1234_5674};
    vecs[3]  = '{A_CNT,  32'hFFFF_FFFF, CNT_MASK};
    vecs[4]  = '{A_CNT,  32'h0000_0000, 32'h0000_0000};
    vecs[5]  = '{3'd5,   32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6]  = '{3'd7,   32'h0000_0001, 32'h0000_0000};
    vecs[7]  = '{A_PAT,  32'hCAFE_F00D, HAS_FILL ? 32'hCAFE_F00D : 32'h0};
    vecs[8]  = '{A_CTRL, 32'h0000_0028, 32'h0000_0008};
    vecs[9]  = '{A_CTRL, 32'h0000_0010, HAS_FILL ? 32'h10 : 32'h0};
    vecs[10] = '{A_CTRL, 32'h0000_0000, 32'h0000_0000};
    foreach (vecs[i]) begin
      reg_write(vecs[i].addr, vecs[i].wdata);
      reg_read(vecs[i].addr, v);
      check($sformatf("regvec%0d", i), v, vecs[i].exp);
    end
    check("regvec_no_bus", 32'(act_q.size()), 32'd0);

    // ---- basic copy, no stalls ----
    start_xfer(32'h1000, 32'h2000, 3, 3, 1'b0, '0, 32'h0);
    finish_xfer("copy3", 32'h1000, 32'h2000, 3, 3, 1'b0, 32'h04);

    // ---- same copy, 5-cycle stall on every beat ----
    fixed_stall = 5;
    start_xfer(32'h1000, 32'h2000, 3, 3, 1'b0, '0, 32'h0);
    finish_xfer("stall5", 32'h1000, 32'h2000, 3, 3, 1'b0, 32'h04);
    fixed_stall = 0;

    // ---- COUNT=0 start: FIN only, DONE two cycles after the write ----
    reg_write(A_CTRL, 32'h44);
    reg_write(A_CNT, 32'h0);
    act_base = act_q.size();
    rd_base = n_rd_started;
    reg_write(A_CTRL, 32'h09);
    check("zero_irq_early", 32'(irq), 32'd0);
    @(negedge clk);
    check("zero_irq", 32'(irq), 32'd1);
    reg_read(A_CTRL, v);
    check("zero_status", v, 32'h0C);
    check("zero_no_bus", 32'(act_q.size() - act_base), 32'd0);
    reg_write(A_CTRL, 32'h04);
    check("zero_irq_cleared", 32'(irq), 32'd0);
    reg_read(A_CTRL, v);
    check("zero_status_cleared", v, 32'h0);

    // ---- abort during the 4th read while stalled ----
    start_xfer(32'h3000, 32'h4000, 10, 4, 1'b0, '0, 32'h0);
    abort_at = rd_base + 4;
    k = 0;
    while (n_rd_started - rd_base < 4 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check("abort_reached_rd4", 32'(n_rd_started - rd_base), 32'd4);
    reg_write(A_CTRL, 32'h20);
    finish_xfer("abort", 32'h3000, 32'h4000, 10, 4, 1'b0, 32'h44);
    abort_at = 0;
    reg_write(A_CTRL, 32'h20);
    reg_read(A_CTRL, v);
    check("abort_idle_ignored", v, 32'h44);

    // ---- host writes while busy are ignored ----
    fixed_stall = 4;
    start_xfer(32'h6000, 32'h7000, 3, 3, 1'b0, '0, 32'h0);
    reg_write(A_SRC, 32'h5);
    reg_write(A_DST, 32'h123);
    reg_write(A_CNT, 32'd99);
    reg_write(A_CTRL, 32'h1);
    finish_xfer("busy_wr", 32'h6000, 32'h7000, 3, 3, 1'b0, 32'h04);
    fixed_stall = 0;
    reg_write(A_SRC, 32'h5);
    reg_read(A_SRC, v);
    check("idle_src_align", v, 32'h4);

`ifdef BUS_DMA_FILL_EN
    // ---- fill mode with destination wrap ----
    start_xfer(32'h100, 32'hFFFF_FFF8, 3, 3, 1'b1, 32'hDEAD_BEEF, 32'h10);
    finish_xfer("fill", 32'h100, 32'hFFFF_FFF8, 3, 3, 1'b1, 32'h14);
    check("fill_no_reads", 32'(n_rd_started - rd_base), 32'd0);
`endif

    // ---- randomized copies with random stalls and IRQ enable ----
    rand_stall = 1'b1;
    for (int t = 0; t < 6; t++) begin
      s = 32'h0001_0000 + 32'($urandom_range(0, 255)) * 32'd64;
      d = 32'h0002_0000 + 32'($urandom_range(0, 255)) * 32'd64;
      c = 32'($urandom_range(1, 6));
      ien = 1'($urandom_range(0, 1));
      start_xfer(s, d, c, int'(c), 1'b0, '0, {28'h0, ien, 3'b000});
      finish_xfer($sformatf("rand%0d", t), s, d, c, int'(c), 1'b0, {28'h0, ien, 3'b100});
      check($sformatf("rand%0d_irq", t), 32'(irq), 32'(ien));
    end
    rand_stall = 1'b0;

    // ---- reset in the middle of a stalled beat ----
    fixed_stall = 3;
    start_xfer(32'h8000, 32'h9000, 5, 5, 1'b0, '0, 32'h08);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_m_read", 32'(m_read), 32'd0);
    check("midrst_m_write", 32'(m_write), 32'd0);
    check("midrst_m_address", m_address, 32'd0);
    check("midrst_readdata", s_readdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fixed_stall = 0;
    reg_read(A_SRC, v);  check("midrst_src", v, 32'd0);
    reg_read(A_CNT, v);  check("midrst_count", v, 32'd0);
    reg_read(A_CTRL, v); check("midrst_ctrl", v, 32'd0);
    check("midrst_irq", 32'(irq), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_dma.md
BUS_DMA -- requirements
Module: bus_dma

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the word-count register (1..24).
REQ-002 clk  in  1  system clock; all logic is on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 Register (responder) port signals:
- s_address  in  3  word index of the register.
- s_read  in  1  register read strobe.
- s_write  in  1  register write strobe.
- s_writedata  in  32  register write data.
- s_readdata  out  32  register read data.
REQ-005 Initiator port signals:
- m_address  out  32  bus address.
- m_read  out  1  bus read request.
- m_write  out  1  bus write request.
- m_writedata  out  32  bus write data.
- m_byteenable  out  4  byte lanes; always 4'b1111.
- m_readdata  in  32  bus read data.
- m_waitrequest  in  1  bus stall.
REQ-006 irq  out  1  interrupt, level.

Function
REQ-007 Register map:
- 0 SRC: source address.
- 1 DST: destination address.
- 2 COUNT: CNT_W bits, zero-extended on read.
- 3 CTRL/STATUS.
- 4 PATTERN: fill pattern (see REQ-025).
- Unmapped addresses read 0 and ignore writes.
REQ-008 SRC and DST SHALL have bits [1:0] forced to 0 on write, so all transfers are word-aligned.
REQ-009 CTRL/STATUS bits:
- bit0 START: write 1 to start; reads 0.
- bit1 BUSY: read-only.
- bit2 DONE: sticky; write 1 clears it.
- bit3 IRQ_EN.
- bit4 FILL.
- bit5 ABORT: write 1 to abort; reads 0.
- bit6 ABORTED: sticky; write 1 clears it.
REQ-010 s_readdata SHALL be registered and valid the cycle after s_read; it holds its value otherwise.
REQ-011 The state machine SHALL have states IDLE, RD, WR and FIN.
REQ-012 IDLE: START=1 with COUNT≠0 goes to RD and sets BUSY; START=1 with COUNT=0 goes to FIN with no bus traffic.
REQ-013 RD: m_read=1 and m_address=SRC; when m_waitrequest=0 in that cycle, capture m_readdata into the data buffer and go to WR.
REQ-014 WR: m_write=1, m_address=DST and m_writedata=buffer; when m_waitrequest=0, SRC+=4, DST+=4, COUNT-=1, then go to RD if the new COUNT≠0, else FIN.
REQ-015 FIN: lasts one cycle, sets DONE, clears BUSY, returns to IDLE.
REQ-016 m_read and m_write SHALL never be asserted together, and SHALL be 0 in IDLE and FIN.
REQ-017 m_address, m_writedata, m_read and m_write SHALL be held stable while m_waitrequest=1.
REQ-018 Address increments SHALL wrap modulo 2^32.
REQ-019 While BUSY, writes to SRC, DST, COUNT and PATTERN SHALL be ignored, and START SHALL be ignored; IRQ_EN, DONE-clear and ABORT SHALL still take effect.
REQ-020 ABORT while BUSY SHALL let the current beat finish its handshake (the current RD or WR completes with waitrequest low), then go to FIN and set ABORTED as well as DONE; ABORT while IDLE SHALL be ignored.
REQ-021 A DONE-clear write in the same cycle FIN sets DONE SHALL leave DONE=1 (set wins).
REQ-022 irq SHALL equal DONE & IRQ_EN, driven from flops.
REQ-023 SRC, DST and COUNT SHALL reflect live progress while BUSY and the final values afterwards.

Reset
REQ-024 On rst_n low, immediately:
- state = IDLE.
- SRC, DST, COUNT, PATTERN and buffer = 0.
- All CTRL bits = 0.
- m_read = m_write = 0, m_address = m_writedata = 0.
- s_readdata = 0, irq = 0.
- Reset mid-transfer abandons the bus beat without a handshake.

Configuration
REQ-025 Macro BUS_DMA_FILL_EN defined:
- PATTERN register exists.
- FILL=1 at START skips RD; every beat is WR with m_writedata=PATTERN, and SRC is unchanged.
REQ-026 Macro BUS_DMA_FILL_EN undefined:
- PATTERN and FILL read 0, writes to them are ignored.
- No fill logic is synthesized.

Structure
REQ-027 A shared package bus_dma_pkg SHALL hold the state enum, the register index constants and the CTRL bit position constants.
REQ-028 The block SHALL be a single module with no sub-modules; the register file and state machine live in bus_dma.

Verification
REQ-029 SRC=0x1000, DST=0x2000, COUNT=3, START, with zero waitrequest:
- 3 reads from 0x1000/4/8 alternating with 3 writes to 0x2000/4/8, data copied.
- DONE=1, COUNT=0, SRC=0x100C.
REQ-030 Same transfer with m_waitrequest held high 5 cycles on each beat: outputs stay stable during the stall, data is identical, and the transfer takes 3 beats.
REQ-031 COUNT=0 then START: no m_read or m_write, DONE=1 two cycles after the write; with IRQ_EN=1, irq=1.
REQ-032 COUNT=10, ABORT during the 4th read with waitrequest high: that read and its write complete, then FIN; DONE=1, ABORTED=1, COUNT=6.
REQ-033 BUS_DMA_FILL_EN defined, FILL=1, PATTERN=0xDEADBEEF, DST=0xFFFFFFF8, COUNT=3: writes go to 0xFFFFFFF8, 0xFFFFFFFC and 0x00000000 (wrap), with no reads.
REQ-034 Writing SRC=0x5 while BUSY: SRC is unchanged; after idle, writing SRC=0x5 reads back 0x4.
